// File: rtl/multi_edge_det.sv
// multi_edge_det: per-channel synchronised, debounced edge detector with mode select, sticky flags and saturating counters
module multi_edge_det #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sig,
    input  logic [2*WIDTH-1:0]     mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       level,
    output logic [WIDTH-1:0]       evt,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] count,
    output logic                   irq
);
    localparam int DB_W = $clog2(DEBOUNCE) + 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] s;
        logic [DB_W-1:0]        db;
        logic [CNT_W-1:0]       cnt;
        logic                   lv, ev, st, sync, accept;

        assign sync   = s[SYNC_STAGES-1];
        assign accept = (sync != lv) && (db == DB_MAX);

        // synchroniser chain, s[0] nearest the pin
        always_ff @(posedge clk or posedge rst)
            if (rst) s <= '0;
            else     s <= {s[SYNC_STAGES-2:0], sig[i]};

        // debounce: a new level is accepted only after DEBOUNCE consecutive differing cycles
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                db <= '0;
                lv <= 1'b0;
                ev <= 1'b0;
            end else begin
                db <= (sync == lv || accept) ? '0 : db + 1'b1;
                lv <= accept ? sync : lv;
                ev <= accept & ((sync & mode[2*i]) | (~sync & mode[2*i+1]));
            end

        // sticky flag and saturating count; an event coinciding with clear is kept
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                st  <= 1'b0;
                cnt <= '0;
            end else begin
                st  <= ev | (st & ~clr[i]);
                cnt <= ev ? (clr[i] ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1))
                          : (clr[i] ? '0 : cnt);
            end

        assign level[i]                 = lv;
        assign evt[i]                   = ev;
        assign sticky[i]                = st;
        assign count[i*CNT_W +: CNT_W]  = cnt;
    end

    assign irq = |sticky;
endmodule

// File: tb/tb_multi_edge_det.sv
// tb_multi_edge_det: directed scoreboard bench for multi_edge_det
module tb_multi_edge_det;
    typedef struct {
        int   ch;
        logic lvl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sig = 8'hFF;
    logic [15:0] mode = 16'hFFFF;
    logic [7:0]  clr = 8'h00;
    logic [7:0]  level, evt, sticky;
    logic [63:0] count;
    logic        irq;

    logic [0:0]  sig3 = 1'b0;
    logic [1:0]  mode3 = 2'b11;
    logic [0:0]  clr3 = 1'b0;
    logic [0:0]  level3, evt3, sticky3;
    logic [2:0]  count3;
    logic        irq3;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t q3[$];
    logic [7:0] pevt = 8'h00;
    logic       pevt3 = 1'b0;

    multi_edge_det dut (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
        .level(level), .evt(evt), .sticky(sticky), .count(count), .irq(irq)
    );

    multi_edge_det #(.WIDTH(1), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .sig(sig3), .mode(mode3), .clr(clr3),
        .level(level3), .evt(evt3), .sticky(sticky3), .count(count3), .irq(irq3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every event pulse pops the next expected event and is compared
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                if (evt[i]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL evt unexpected ch%0d level=%0b", i, level[i]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.ch != i || e.lvl !== level[i] || pevt[i]) begin
                            errors++;
                            $display("FAIL evt got ch%0d lvl=%0b repeat=%0b want ch%0d lvl=%0b repeat=0",
                                     i, level[i], pevt[i], e.ch, e.lvl);
                        end
                    end
                end
            end
            if (evt3[0]) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL evt3 unexpected level=%0b", level3[0]);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    if (e.lvl !== level3[0] || pevt3) begin
                        errors++;
                        $display("FAIL evt3 got lvl=%0b repeat=%0b want lvl=%0b repeat=0",
                                 level3[0], pevt3, e.lvl);
                    end
                end
            end
        end
        pevt  <= evt;
        pevt3 <= evt3[0];
    end

    initial begin
        // T1: reset with all inputs high, then release with mode=both
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_evt", evt, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_count", count, 0);
        chk("rst_irq", irq, 0);
        chk("rst_count3", count3, 0);
        for (int i = 0; i < 8; i++) q.push_back('{i, 1'b1});
        rst = 1'b0;
        repeat (5) tick();
        chk("t1_evt_early", evt, 8'h00);
        tick();
        chk("t1_evt", evt, 8'hFF);
        chk("t1_level", level, 8'hFF);
        tick();
        chk("t1_evt_once", evt, 8'h00);
        chk("t1_count", count, 64'h0101010101010101);
        chk("t1_sticky", sticky, 8'hFF);
        chk("t1_irq", irq, 1);
        clr = 8'hFF;
        tick();
        clr = 8'h00;
        chk("clr_all_count", count, 0);
        chk("clr_all_irq", irq, 0);

        // T2: debounce, starting from all levels low with channels off
        mode = 16'h0000;
        sig  = 8'h00;
        repeat (12) tick();
        chk("t2_idle_level", level, 0);
        mode = 16'h0003;
        sig[0] = 1'b1;
        repeat (3) tick();
        sig[0] = 1'b0;
        repeat (10) tick();
        chk("t2_glitch_level", level, 0);
        chk("t2_glitch_count", count[7:0], 0);
        q.push_back('{0, 1'b1});
        q.push_back('{0, 1'b0});
        sig[0] = 1'b1;
        repeat (4) tick();
        sig[0] = 1'b0;
        repeat (12) tick();
        chk("t2_pulse_count", count[7:0], 2);
        chk("t2_pulse_level", level, 0);

        // T3: ch1 rise only, ch2 fall only, ch3 off
        mode = 16'h0024;
        q.push_back('{1, 1'b1});
        sig = 8'h0E;
        repeat (10) tick();
        chk("t3_level_hi", level, 8'h0E);
        q.push_back('{2, 1'b0});
        sig = 8'h00;
        repeat (10) tick();
        chk("t3_level_lo", level, 8'h00);
        chk("t3_count1", count[15:8], 1);
        chk("t3_count2", count[23:16], 1);
        chk("t3_count3", count[31:24], 0);

        // T5: clear racing an event, then a clear on an idle cycle
        mode = 16'h0003;
        q.push_back('{0, 1'b1});
        sig[0] = 1'b1;
        repeat (6) tick();
        chk("t5_evt0", evt[0], 1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("t5_race_count", count[7:0], 1);
        chk("t5_race_sticky", sticky[0], 1);
        clr = 8'hFE;
        tick();
        clr = 8'h00;
        chk("t5_others_sticky", sticky, 8'h01);
        chk("t5_irq_kept", irq, 1);
        clr = 8'h01;
        tick();
        clr = 8'h00;
        chk("t5_idle_count", count[7:0], 0);
        chk("t5_idle_sticky", sticky, 0);
        chk("t5_irq_clear", irq, 0);

        // T6: reset in the middle of a debounce run
        mode = 16'h0000;
        sig[0] = 1'b0;
        repeat (12) tick();
        chk("t6_pre_level", level[0], 0);
        mode = 16'h0003;
        sig[0] = 1'b1;
        repeat (3) tick();
        sig[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_level", level[0], 0);
        chk("t6_count", count[7:0], 0);
        q.push_back('{0, 1'b1});
        sig[0] = 1'b1;
        repeat (5) tick();
        chk("t6_db_restart_early", evt[0], 0);
        tick();
        chk("t6_db_restart_evt", evt[0], 1);
        repeat (3) tick();

        // T4: saturation of a 3-bit counter over 10 toggles
        for (int t = 0; t < 10; t++) begin
            q3.push_back('{0, (t % 2 == 0)});
            sig3 = ~sig3;
            repeat (8) tick();
            if (t == 5) chk("t4_count_6", count3, 6);
        end
        chk("t4_count_sat", count3, 7);
        chk("t4_sticky", sticky3, 1);
        chk("t4_irq", irq3, 1);

        repeat (4) tick();
        chk("q_drained", q.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
